muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, located in the EX stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU issued from EX and services MTHI/MTLO writes.
- Presents HI/LO to the MFHI/MFLO result path.
- Exports start and busy to the stall detector. The stall detector holds any HI/LO-touching instruction in IF/ID while start|busy is high.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (and MADD when enabled); legal range 1..31.
- DIV_CYCLES, 10, busy duration for DIV/DIVU; legal range 1..31.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  EX-stage instruction is a mult/div op this cycle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD (MADD only when the optional feature is enabled).
- cancel  in  1  exception/interrupt in the MEM stage; suppresses start and MTHI/MTLO this cycle.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- mthi  in  1  write HI from wdata.
- mtlo  in  1  write LO from wdata.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress (registered).
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, reset_n=0): busy=0, hi=0, lo=0, counter=0, result latches=0. Asserting reset mid-operation aborts the operation; no HI/LO commit follows deassertion.
- States: IDLE (counter==0) and RUN (counter!=0); busy = (counter!=0).
- IDLE accepts start when cancel=0 and op is legal:
  - Compute the 64-bit result from a/b and hold it in internal result registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy rises at that edge.
- RUN decrements counter each cycle. On the edge where counter goes 1->0:
  - Commit the result to hi/lo.
  - busy falls at the same edge, so busy is high exactly N cycles.
  - The new hi/lo are visible the first cycle busy=0.
- start while busy=1 is ignored. The stall detector makes this impossible; the verification engineer flags it with an assertion.
- start with cancel=1, or an illegal op: no effect, state stays IDLE.
- MULT: {hi,lo} = signed a * signed b, full 64 bits.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder, sign of dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, remainder to hi.
- Divide by zero (b==0): the operation runs full latency and busy behaves normally; hi/lo keep their prior values (no commit).
- MTHI/MTLO:
  - Write at the clock edge when busy=0 and cancel=0; hi/lo are updated the next cycle.
  - Ignored while busy=1 (assertion).
  - mthi and mtlo together write both.
  - Same-cycle start+mtlo: mtlo writes first. The op's commit overwrites it later, which is legal ordering since mtlo precedes the op.
- The counter wraps nowhere: it only loads from IDLE and saturates at 0.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op=4 (MADD) is legal: {hi,lo} <= {hi,lo} + signed(a)*signed(b), mod 2^64.
  - The accumulate uses the hi/lo values at the commit edge.
  - Latency is MULT_CYCLES.
- Undefined: op=4..7 illegal; start is ignored, busy stays 0.

Test Plan:
- Reset then MULT a=0xFFFFFFFE b=0x00000003, start 1 cycle -> busy high cycles 1..5, then hi=0xFFFFFFFF lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy exactly 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=1.
- mthi wdata=0x12345678, then DIV b=0 -> busy 10 cycles, hi stays 0x12345678; start with cancel=1 -> busy stays 0.
- DIV started, reset_n pulsed low at busy cycle 4 -> busy=0, hi=lo=0 immediately, no later commit.
- MULDIV_MADD_EN: mthi 0, mtlo 0xFFFFFFFF, MADD a=1 b=1 -> hi=1 lo=0. Without the macro, op=4 -> busy never rises.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and MTHI/MTLO path.
// Optional MADD accumulate (op=4) is compiled in when MULDIV_MADD_EN is defined.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_res;
  logic        r_res_vld;
  logic        r_madd;
  logic [31:0] r_hi, r_lo;

  logic        w_legal, w_accept, w_is_div, w_is_sdiv, w_commit, w_mt_ok;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q, w_r;
  logic [63:0] w_prod_s, w_prod_u, w_res, w_commit_val;

`ifdef MULDIV_MADD_EN
  assign w_legal = (op <= 3'd4);
`else
  assign w_legal = (op <= 3'd3);
`endif

  assign w_accept  = start & ~cancel & w_legal & (r_state == S_IDLE);
  assign w_is_div  = (op == 3'd2) | (op == 3'd3);
  assign w_is_sdiv = (op == 3'd2);
  assign w_mt_ok   = (r_state == S_IDLE) & ~cancel;

  // Signed product is the low 64 bits of the product of sign-extended operands.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; the -2^31 / -1 case falls out as 0x80000000 rem 0.
  assign w_a_mag  = (w_is_sdiv && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag  = (w_is_sdiv && b[31]) ? (32'd0 - b) : b;
  assign w_b_safe = (w_b_mag == '0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_is_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = (w_is_sdiv && a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_res = '0;
    case (op)
      3'd0, 3'd4: w_res = w_prod_s;
      3'd1:       w_res = w_prod_u;
      3'd2, 3'd3: w_res = {w_r, w_q};
      default:    w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 5'd1;
        if (r_cnt == 5'd1) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_madd    <= 1'b0;
    end else if (w_accept) begin
      r_res     <= w_res;
      r_res_vld <= ~(w_is_div && (b == '0));
      r_madd    <= (op == 3'd4);
    end
  end

  assign w_commit     = (r_state == S_RUN) && (r_cnt == 5'd1) && r_res_vld;
  assign w_commit_val = r_madd ? ({r_hi, r_lo} + r_res) : r_res;

  // Commit and MTHI/MTLO are mutually exclusive: writes require IDLE, commit happens in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_commit_val[63:32];
      r_lo <= w_commit_val[31:0];
    end else if (w_mt_ok) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset_n, start, cancel, mthi, mtlo;
  logic [2:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definitions using 64-bit integers.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ua = {32'd0, ia};
    ub = {32'd0, ib};
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin up = ua * ub; {m_hi, m_lo} = up; end
      3'd2: if (ib != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd3: if (ib != 0) begin m_lo = ia / ib; m_hi = ia % ib; end
      3'd4: begin p = longint'({m_hi, m_lo}) + sa * sb; {m_hi, m_lo} = p; end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input bit with_mtlo, input logic [31:0] wd, input string tag);
    int unsigned n;
    int unsigned expn;
    expn = (o == 3'd2 || o == 3'd3) ? DC : MC;
    start = 1'b1; op = o; a = ia; b = ib;
    mtlo = with_mtlo; wdata = wd;
    step();
    start = 1'b0; mtlo = 1'b0;
    if (with_mtlo) begin
      m_lo = wd;
      check({tag, "_mtlo_first"}, {32'd0, lo}, {32'd0, wd});
    end
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(expn));
    model_apply(o, ia, ib);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic write_hl(input bit wh, input bit wl, input logic [31:0] wd);
    mthi = wh; mtlo = wl; wdata = wd;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int unsigned sel;

    reset_n = 1'b0; start = 1'b0; op = '0; cancel = 1'b0;
    a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    step(); step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    reset_n = 1'b1;
    step();

    run_op(3'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0, '0, "mult");
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0, "multu");
    check("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, '0, "div");
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, '0, "divu");
    check("divu_const", {hi, lo}, 64'h00000001_7FFFFFFC);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

    write_hl(1'b1, 1'b0, 32'h12345678);
    check("mthi", {32'd0, hi}, 64'h12345678);
    run_op(3'd2, 32'd100, 32'd0, 1'b0, '0, "div0");
    check("div0_hi_kept", {32'd0, hi}, 64'h12345678);

    run_op(3'd3, 32'd55, 32'd0, 1'b1, 32'hCAFEF00D, "mtlo_start_div0");
    run_op(3'd1, 32'd7, 32'd9, 1'b1, 32'h0BADBEEF, "mtlo_start_mul");

    cancel = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    mthi = 1'b1; wdata = 32'hDEADDEAD;
    step();
    start = 1'b0; mthi = 1'b0; cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_mthi", {32'd0, hi}, {32'd0, m_hi});

`ifdef MULDIV_MADD_EN
    write_hl(1'b1, 1'b1, 32'd0);
    write_hl(1'b0, 1'b1, 32'hFFFFFFFF);
    run_op(3'd4, 32'd1, 32'd1, 1'b0, '0, "madd");
    check("madd_const", {hi, lo}, 64'h00000001_00000000);
    run_op(3'd4, 32'hFFFFFFFF, 32'd5, 1'b0, '0, "madd_neg");
`else
    start = 1'b1; op = 3'd4; a = 32'd1; b = 32'd1;
    step();
    start = 1'b0;
    check("op4_busy", {63'd0, busy}, 64'd0);
    repeat (MC + 2) step();
    check("op4_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) write_hl(1'b1, 1'b1, $urandom);
      run_op(ro, ra, rb, 1'b0, '0, "rand");
    end

    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    step();
    reset_n = 1'b1;
    repeat (DC + 4) step();
    check("postrst_busy", {63'd0, busy}, 64'd0);
    check("postrst_hilo", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
